piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the team's serial-in parallel-out shift register.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock.
- Drives `sout` into the consumer's serial `in` and `sout_valid` into the consumer's clock-qualify/enable.
- Has a one-word holding buffer, so consecutive frames stream back-to-back with no idle cycle.

Parameters:
- width, 8, data word width in bits (>= 2).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  width  parallel word to serialize.
- sline  input  1  bit order, sampled with `din`. 0 = MSB first (matches a left-shifting consumer). 1 = LSB first (matches a right-shifting consumer).
- in_valid  input  1  `din`/`sline` valid.
- in_ready  output  1  holding buffer can accept a word.
- sout  output  1  serial data bit.
- sout_valid  output  1  `sout` carries a frame bit this cycle.
- frame_done  output  1  high during the last bit cycle of a frame.
- busy  output  1  shifter active or holding buffer occupied.

Behaviour:
- Reset:
  - Applies at a `clk` edge with `rst` = 1 and overrides everything else.
  - Clears the shifter, holding buffer, bit counter and state (IDLE).
  - Registered outputs after reset: `sout` = 0, `sout_valid` = 0, `frame_done` = 0, `busy` = 0.
  - `in_ready` = !hold_full && !rst, so it is 0 while `rst` is high and 1 after.
  - Reset mid-frame abandons the frame and the held word; no partial-frame completion.
- Handshake:
  - A transfer occurs at an edge where `in_valid` && `in_ready`.
  - The accepted `din` and `sline` are written to the holding buffer and `hold_full` is set.
  - `din` is ignored when `in_ready` = 0; the producer must hold `din` stable until accepted.
- Load:
  - The shifter loads from the holding buffer at an edge where `hold_full` && (state == IDLE || last bit cycle).
  - A load clears `hold_full`.
  - If an accept and a load coincide, `hold_full` stays 1 (new word in, old word out).
- Latency:
  - Word accepted at edge N is loaded at edge N+1.
  - Its first bit is on `sout` with `sout_valid` = 1 from edge N+1.
- States:
  - IDLE to SHIFT on load.
  - SHIFT to SHIFT on the last bit cycle with `hold_full` (back-to-back frames, no gap).
  - SHIFT to IDLE on the last bit cycle without `hold_full`.
- Bit counter: counts 0..width-1 within a frame; a frame is width cycles long.
- Bit order:
  - `sline` = 0: bit k of the frame is `word[width-1-k]`.
  - `sline` = 1: bit k of the frame is `word[k]`.
  - Order is fixed per word at accept time; changing `sline` mid-frame has no effect.
- Outputs are registered:
  - `sout` and `sout_valid` update on the same edge.
  - `frame_done` = 1 exactly while the final frame bit is presented.
- Idle outputs: in IDLE, `sout` = 0 and `sout_valid` = 0.
- busy = (state == SHIFT) || hold_full.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Each frame is width+1 cycles; the extra final bit is even parity (XOR of all `width` data bits).
  - `frame_done` is asserted on the parity bit.
  - The counter spans 0..width.
- Undefined: no parity bit; frame is exactly width cycles.

Test Plan:
- Reset/idle: `rst` = 1 for 2 cycles, then 0 with `in_valid` = 0 -> `sout` = 0, `sout_valid` = 0, `busy` = 0, `in_ready` = 1.
- MSB-first: accept 8'hB4 with `sline` = 0 -> from the next edge `sout` = 1,0,1,1,0,1,0,0 with `sout_valid` = 1 for 8 cycles; `frame_done` only on the 8th; the downstream left-shifting register then reads 8'hB4.
- LSB-first: accept 8'hB4 with `sline` = 1 -> `sout` = 0,0,1,0,1,1,0,1; a right-shifting consumer reads 8'hB4.
- Back-to-back: hold `in_valid` = 1 with 8'hA5 then 8'h3C -> 16 consecutive `sout_valid` cycles, no gap; `in_ready` drops while the buffer is full; 8'h3C is accepted only after 8'hA5 loads.
- Reset mid-frame: accept 8'hFF, assert `rst` after 3 bits -> next cycle `sout_valid` = 0, `busy` = 0; the rest of the frame is never emitted.
- PISO_PARITY_EN defined: accept 8'h07, `sline` = 0 -> 9 bits `0,0,0,0,0,1,1,1,1` (parity 1), `frame_done` on the 9th.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage with a one-word holding buffer for back-to-back frames.
// Optional build macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    input  logic             sline,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = width + 1;
`else
    localparam int FRAME_LEN = width;
`endif
    localparam int CNT_W = $clog2(width + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [width-1:0]   hold_data_r;
    logic               hold_sline_r;
    logic               hold_full_r;
    logic               hold_full_nx_s;
    logic [width-1:0]   word_r;
    logic               order_r;
    logic               parity_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic               sout_r;
    logic               sout_nx_s;
    logic               valid_r;
    logic               valid_nx_s;
    logic               done_r;
    logic               done_nx_s;
    logic               accept_s;
    logic               last_s;
    logic               load_s;

    function automatic logic even_parity(input logic [width-1:0] w);
        return ^w;
    endfunction

    // Bit k of a frame; index width selects the trailing parity bit when enabled.
    function automatic logic frame_bit(input logic [width-1:0] w, input logic lsb_first,
                                       input logic [CNT_W-1:0] k, input logic par);
        logic [width-1:0] shifted;
        logic             result;
        shifted = '0;
        if (k >= CNT_W'(width)) begin
            result = par;
        end else if (lsb_first) begin
            shifted = w >> k;
            result  = shifted[0];
        end else begin
            shifted = w << k;
            result  = shifted[width-1];
        end
        return result;
    endfunction

    assign accept_s   = in_valid && in_ready;
    assign last_s     = (state_r == SHIFT) && (cnt_r == CNT_W'(FRAME_LEN - 1));
    assign load_s     = hold_full_r && ((state_r == IDLE) || last_s);
    assign in_ready   = !hold_full_r && !rst;
    assign busy       = (state_r == SHIFT) || hold_full_r;
    assign sout       = sout_r;
    assign sout_valid = valid_r;
    assign frame_done = done_r;

    // Next-state and next-output computation.
    always_comb begin
        state_nx_s     = state_r;
        hold_full_nx_s = hold_full_r;
        cnt_nx_s       = cnt_r;
        sout_nx_s      = 1'b0;
        valid_nx_s     = 1'b0;
        done_nx_s      = 1'b0;

        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_nx_s = SHIFT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s && !load_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase

        if (accept_s) begin
            hold_full_nx_s = 1'b1;
        end else if (load_s) begin
            hold_full_nx_s = 1'b0;
        end else begin
            hold_full_nx_s = hold_full_r;
        end

        // A load starts the new frame at bit 0, otherwise advance within the current one.
        if (load_s) begin
            cnt_nx_s   = '0;
            sout_nx_s  = frame_bit(hold_data_r, hold_sline_r, CNT_W'(0), even_parity(hold_data_r));
            valid_nx_s = 1'b1;
            done_nx_s  = 1'b0;
        end else if ((state_r == SHIFT) && !last_s) begin
            cnt_nx_s   = cnt_r + CNT_W'(1);
            sout_nx_s  = frame_bit(word_r, order_r, cnt_r + CNT_W'(1), parity_r);
            valid_nx_s = 1'b1;
            done_nx_s  = ((cnt_r + CNT_W'(1)) == CNT_W'(FRAME_LEN - 1));
        end else begin
            cnt_nx_s   = '0;
            sout_nx_s  = 1'b0;
            valid_nx_s = 1'b0;
            done_nx_s  = 1'b0;
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            hold_data_r  <= '0;
            hold_sline_r <= 1'b0;
            hold_full_r  <= 1'b0;
            word_r       <= '0;
            order_r      <= 1'b0;
            parity_r     <= 1'b0;
            cnt_r        <= '0;
            sout_r       <= 1'b0;
            valid_r      <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            hold_full_r <= hold_full_nx_s;
            cnt_r       <= cnt_nx_s;
            sout_r      <= sout_nx_s;
            valid_r     <= valid_nx_s;
            done_r      <= done_nx_s;
            if (accept_s) begin
                hold_data_r  <= din;
                hold_sline_r <= sline;
            end else begin
                hold_data_r  <= hold_data_r;
                hold_sline_r <= hold_sline_r;
            end
            if (load_s) begin
                word_r   <= hold_data_r;
                order_r  <= hold_sline_r;
                parity_r <= even_parity(hold_data_r);
            end else begin
                word_r   <= word_r;
                order_r  <= order_r;
                parity_r <= parity_r;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized scoreboard bench for piso_serializer: expected serial bits are queued per
// accepted word and a negedge monitor pops and compares them as sout_valid appears.
module tb_piso_serializer;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         sline;
    logic         in_valid;
    logic         in_ready;
    logic         sout;
    logic         sout_valid;
    logic         frame_done;
    logic         busy;

    piso_serializer #(.width(W)) dut (
        .clk(clk), .rst(rst), .din(din), .sline(sline), .in_valid(in_valid),
        .in_ready(in_ready), .sout(sout), .sout_valid(sout_valid),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic b; logic done; } exp_t;
    typedef struct packed { logic [W-1:0] w; logic s; } word_t;
    exp_t  exp_q[$];
    word_t word_q[$];

    int total = 0;
    int bad = 0;
    int m_rem = 0;        // frame bits still to be presented, including the current one
    bit m_hold = 1'b0;    // model: a word waits in the buffer
    bit last_acc = 1'b0;
    int run_len = 0;
    int max_run = 0;
    int bit_idx = 0;
    logic [W-1:0] left_sr = '0;
    logic [W-1:0] right_sr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w, input logic s);
        exp_t e;
        logic [W-1:0] t;
        for (int k = 0; k < W; k++) begin
            t = s ? (w >> k) : (w << k);
            e.b = s ? t[0] : t[W-1];
            e.done = (k == LEN - 1);
            exp_q.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b = ^w;
        e.done = 1'b1;
        exp_q.push_back(e);
`endif
        word_q.push_back({w, s});
    endtask

    // One clock: update the frame-level model at the edge, then check status at negedge.
    task automatic step();
        bit last;
        bit load;
        @(posedge clk);
        last_acc = 1'b0;
        if (rst) begin
            m_hold = 1'b0;
            m_rem = 0;
            bit_idx = 0;
            exp_q.delete();
            word_q.delete();
        end else begin
            last = (m_rem == 1);
            load = m_hold && (m_rem == 0 || last);
            last_acc = in_valid && !m_hold;
            if (last_acc) push_word(din, sline);
            if (load) m_rem = LEN;
            else if (m_rem > 0) m_rem--;
            if (last_acc) m_hold = 1'b1;
            else if (load) m_hold = 1'b0;
        end
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_hold && !rst)});
        check("busy", {31'd0, busy}, {31'd0, (m_rem > 0 || m_hold)});
        check("sout_valid", {31'd0, sout_valid}, {31'd0, (m_rem > 0)});
        if (m_rem == 0) begin
            check("idle_sout", {31'd0, sout}, 32'd0);
            check("idle_done", {31'd0, frame_done}, 32'd0);
        end
    endtask

    task automatic send(input logic [W-1:0] w, input logic s);
        int n;
        in_valid = 1'b1;
        din = w;
        sline = s;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 60);
        if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: pop one expected bit per valid serial cycle.
    always @(negedge clk) begin
        exp_t e;
        word_t wd;
        if (sout_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("unexpected_bit", {31'd0, sout}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sout", {31'd0, sout}, {31'd0, e.b});
                check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
                if (bit_idx < W) begin
                    left_sr = {left_sr[W-2:0], sout};
                    right_sr = {sout, right_sr[W-1:1]};
                end
                bit_idx++;
                if (e.done) begin
                    bit_idx = 0;
                    if (word_q.size() != 0) begin
                        wd = word_q.pop_front();
                        check("consumer_word", {24'd0, (wd.s ? right_sr : left_sr)}, {24'd0, wd.w});
                    end
                end
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pending;
        rst = 1'b1;
        in_valid = 1'b0;
        din = '0;
        sline = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (2) step();

        send(8'hB4, 1'b0);
        repeat (LEN + 2) step();
        send(8'hB4, 1'b1);
        repeat (LEN + 2) step();
        send(8'h07, 1'b0);
        repeat (LEN + 2) step();

        // Back-to-back: second word stalls until the first loads, then streams with no gap.
        max_run = 0;
        send(8'hA5, 1'b0);
        send(8'h3C, 1'b1);
        repeat (2 * LEN + 3) step();
        check("b2b_run", max_run, 2 * LEN);

        send(8'hFF, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_mid_valid", {31'd0, sout_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (LEN + 2) step();
        check("rst_mid_flushed", exp_q.size(), 32'd0);

        pending = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (last_acc || !pending) begin
                pending = ($urandom_range(0, 3) != 0);
                in_valid = pending;
                din = W'($urandom);
                sline = 1'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            if (rst) pending = 1'b0;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2 * LEN + 4) step();
        check("drain_bits", exp_q.size(), 32'd0);
        check("drain_words", word_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
